mod_counter_ctrl: RTL and testbench

MOD_COUNTER_CTRL -- requirements
Module: mod_counter_ctrl

---
 rtl/counter_ctrl_pkg.sv | 6 +
 rtl/mod_counter_ctrl_if.sv | 13 +
 rtl/mod_n_counter.sv | 15 +
 rtl/mod_counter_ctrl.sv | 50 +++++
 tb/tb_mod_counter_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared state type and default sizing for the modulo counter controller
package counter_ctrl_pkg;
    localparam int CC_WIDTH = 4;
    localparam int CC_DEFAULT_MOD = 13;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mod_counter_ctrl_if.sv
// mod_counter_ctrl_if: config/control handshake and status bundle of the modulo counter controller
interface mod_counter_ctrl_if import counter_ctrl_pkg::*; #(parameter int WIDTH = CC_WIDTH);
    logic cfg_valid, cfg_ready, cfg_err, start, stop, tc, busy, done;
    logic [WIDTH-1:0] cfg_mod, cfg_reps, Q, wraps;
    modport master (
        output cfg_valid, cfg_mod, cfg_reps, start, stop,
        input  cfg_ready, cfg_err, Q, tc, busy, done, wraps
    );
    modport slave (
        input  cfg_valid, cfg_mod, cfg_reps, start, stop,
        output cfg_ready, cfg_err, Q, tc, busy, done, wraps
    );
endinterface

// File: rtl/mod_n_counter.sv
// mod_n_counter: registered modulo-N up counter with clear priority and terminal-count flag
module mod_n_counter #(parameter int WIDTH = 4) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] Q,
    output logic             tc
);
    assign tc = Q == modulus - 1'b1;
    always_ff @(posedge clk)
        if (reset || clear) Q <= '0;
        else if (enable) Q <= tc ? '0 : Q + 1'b1;
endmodule

// File: rtl/mod_counter_ctrl.sv
// mod_counter_ctrl: IDLE/RUN/DONE controller with runtime modulus and repeat count around a modulo-N counter
module mod_counter_ctrl import counter_ctrl_pkg::*; #(
    parameter int WIDTH       = CC_WIDTH,
    parameter int DEFAULT_MOD = CC_DEFAULT_MOD
) (
    input logic               clk,
    input logic               reset,
    mod_counter_ctrl_if.slave bus
);
    state_t state, state_n;
    logic [WIDTH-1:0] mod_r, reps_r, wraps_r, q;
    logic cnt_tc, err_r, accept, legal, last, clear;
    mod_n_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk(clk), .reset(reset), .clear(clear), .enable(state == RUN),
        .modulus(mod_r), .Q(q), .tc(cnt_tc)
    );
    always_comb begin
        accept        = state == IDLE && bus.cfg_valid;
        legal         = |bus.cfg_mod[WIDTH-1:1];
        last          = reps_r != '0 && wraps_r == reps_r - 1'b1;
        clear         = state != RUN || bus.stop;
        state_n       = state == IDLE ? (bus.start ? RUN : IDLE) :
                        state == RUN  ? (bus.stop ? IDLE : (cnt_tc && last) ? DONE : RUN) : IDLE;
        bus.Q         = q;
        bus.tc        = state == RUN && cnt_tc;
        bus.busy      = state == RUN;
        bus.done      = state == DONE;
        bus.cfg_ready = state == IDLE;
        bus.cfg_err   = err_r;
        bus.wraps     = wraps_r;
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    // wraps_r + 1 equals reps_r on the final wrap, so one increment covers both cases
    always_ff @(posedge clk)
        if (reset) begin
            mod_r   <= WIDTH'(DEFAULT_MOD);
            reps_r  <= '0;
            wraps_r <= '0;
            err_r   <= 1'b0;
        end else begin
            err_r <= accept && !legal;
            if (accept && legal) begin
                mod_r  <= bus.cfg_mod;
                reps_r <= bus.cfg_reps;
            end
            if (state == IDLE && bus.start) wraps_r <= '0;
            else if (state == RUN && !bus.stop && cnt_tc) wraps_r <= wraps_r + 1'b1;
        end
endmodule

// File: tb/tb_mod_counter_ctrl.sv
// tb_mod_counter_ctrl: scoreboard bench comparing the controller against a cycle model
module tb_mod_counter_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    mod_counter_ctrl_if #(.WIDTH(4)) bus();
    mod_counter_ctrl #(.WIDTH(4), .DEFAULT_MOD(13)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct packed {
        logic [3:0] q;
        logic       tc, busy, done;
        logic [3:0] wraps;
        logic       err, rdy;
    } exp_t;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int busy_cnt, done_cnt;
    int m_st;
    logic [3:0] m_q, m_w, m_mod, m_reps;
    logic m_err;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model(input logic rs, input logic cv, input logic [3:0] cm, input logic [3:0] cr,
                         input logic st, input logic sp);
        if (rs) begin
            m_st = 0; m_q = 0; m_w = 0; m_mod = 4'd13; m_reps = 0; m_err = 0;
        end else if (m_st == 0) begin
            m_err = cv && cm < 4'd2;
            if (cv && cm >= 4'd2) begin m_mod = cm; m_reps = cr; end
            if (st) begin m_st = 1; m_q = 0; m_w = 0; end
        end else if (m_st == 1) begin
            m_err = 0;
            if (sp) begin
                m_st = 0; m_q = 0;
            end else if (m_q == m_mod - 4'd1) begin
                m_q = 0;
                m_w = m_w + 4'd1;
                if (m_reps != 0 && m_w == m_reps) m_st = 2;
            end else m_q = m_q + 4'd1;
        end else begin
            m_err = 0; m_st = 0; m_q = 0;
        end
    endtask
    task automatic drive(input logic cv, input logic [3:0] cm, input logic [3:0] cr,
                         input logic st, input logic sp);
        exp_t e;
        bus.cfg_valid = cv; bus.cfg_mod = cm; bus.cfg_reps = cr; bus.start = st; bus.stop = sp;
        model(reset, cv, cm, cr, st, sp);
        sb.push_back('{m_q, m_st == 1 && m_q == m_mod - 4'd1, m_st == 1, m_st == 2, m_w, m_err, m_st == 0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("Q", 32'(bus.Q), 32'(e.q));
        chk("tc", 32'(bus.tc), 32'(e.tc));
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("done", 32'(bus.done), 32'(e.done));
        chk("wraps", 32'(bus.wraps), 32'(e.wraps));
        chk("cfg_err", 32'(bus.cfg_err), 32'(e.err));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(e.rdy));
        busy_cnt += int'(bus.busy);
        done_cnt += int'(bus.done);
    endtask
    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask
    task automatic go();
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    endtask
    task automatic halt();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    endtask
    task automatic cfg(input logic [3:0] m, input logic [3:0] r, input logic st);
        drive(1'b1, m, r, st, 1'b0);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask
    initial begin
        do_reset();
        do_reset();
        repeat (2) idle();
        // default modulus 13, continuous
        busy_cnt = 0; done_cnt = 0;
        go();
        repeat (40) idle();
        chk("busy_default", busy_cnt, 41);
        chk("done_default", done_cnt, 0);
        cfg(4'd5, 4'd1, 1'b0);
        cfg(4'd0, 4'd0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        idle();
        // mod 5 x 3, start together with stop in IDLE
        cfg(4'd5, 4'd3, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        repeat (18) idle();
        chk("busy_5x3", busy_cnt, 15);
        chk("done_5x3", done_cnt, 1);
        chk("wraps_5x3", 32'(bus.wraps), 3);
        // illegal moduli rejected
        do_reset();
        cfg(4'd1, 4'd2, 1'b0);
        chk("err_mod1", 32'(bus.cfg_err), 1);
        cfg(4'd0, 4'd2, 1'b0);
        idle();
        go();
        repeat (15) idle();
        chk("q_mod13", 32'(bus.Q), 2);
        halt();
        // stop at Q=7
        go();
        for (int i = 0; i < 30 && m_q != 4'd7; i++) idle();
        chk("q_at7", 32'(bus.Q), 7);
        halt();
        chk("ready_after_stop", 32'(bus.cfg_ready), 1);
        // reset mid-run restores default modulus
        cfg(4'd6, 4'd2, 1'b1);
        repeat (8) idle();
        do_reset();
        idle();
        busy_cnt = 0; done_cnt = 0;
        go();
        repeat (14) idle();
        chk("done_after_rst", done_cnt, 0);
        halt();
        // config and start together, start ignored in DONE
        cfg(4'd3, 4'd1, 1'b1);
        idle();
        idle();
        idle();
        chk("done_3x1", 32'(bus.done), 1);
        go();
        chk("idle_after_done", 32'(bus.busy), 0);
        idle();
        // stop on the final terminal count
        cfg(4'd2, 4'd2, 1'b1);
        for (int i = 0; i < 10 && !(m_q == 4'd1 && m_w == 4'd1); i++) idle();
        chk("tc_final", 32'(bus.tc), 1);
        busy_cnt = 0; done_cnt = 0;
        halt();
        idle();
        chk("no_done_on_stop", done_cnt, 0);
        // continuous wrap counter rolls over
        cfg(4'd2, 4'd0, 1'b1);
        repeat (36) idle();
        chk("wraps_roll", 32'(bus.wraps), 2);
        halt();
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
